// File: rtl/tdm_demux_8ch.sv
// rtl/tdm_demux_8ch.sv - 8-channel TDM receive demultiplexer with sync-based frame alignment
module tdm_demux_8ch #(
    parameter int WIDTH  = 1,
    parameter int NUM_CH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      sync,
    output logic [NUM_CH*WIDTH-1:0]   ch_out,
    output logic [NUM_CH*WIDTH-1:0]   frame_out,
    output logic                      frame_valid,
    output logic [2:0]                ch_idx,
    output logic                      locked,
    output logic                      sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                    state, state_n;
    logic [2:0]                idx_n;
    logic [NUM_CH*WIDTH-1:0]   ch_n;
    logic [NUM_CH*WIDTH-1:0]   frame_n;
    logic                      frame_valid_n;
    logic                      sync_err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            ch_idx      <= '0;
            ch_out      <= '0;
            frame_out   <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            ch_idx      <= idx_n;
            ch_out      <= ch_n;
            frame_out   <= frame_n;
            frame_valid <= frame_valid_n;
            sync_err    <= sync_err_n;
        end
    end

    assign locked = (state == RUN);

    always_comb begin
        state_n       = state;
        idx_n         = ch_idx;
        ch_n          = ch_out;
        frame_n       = frame_out;
        frame_valid_n = 1'b0;
        sync_err_n    = 1'b0;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (sync) begin
                        ch_n[0 +: WIDTH] = din;
                        idx_n            = 3'd1;
                        state_n          = RUN;
                    end
                end
                RUN: begin
                    if (sync && ch_idx != 3'd0) begin
                        // Realign on the new sync; the partial frame is abandoned.
                        sync_err_n       = 1'b1;
                        ch_n[0 +: WIDTH] = din;
                        idx_n            = 3'd1;
                    end else begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_idx == 3'(k)) begin
                                ch_n[k*WIDTH +: WIDTH] = din;
                            end
                        end
                        idx_n = ch_idx + 3'd1;
                        // Snapshot includes the ch7 sample landing at this same edge.
                        if (ch_idx == 3'(NUM_CH-1)) begin
                            frame_n       = ch_n;
                            frame_valid_n = 1'b1;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// tb/tb_tdm_demux_8ch.sv - self-checking bench for tdm_demux_8ch against a frame-level reference model
module tb_tdm_demux_8ch;

    localparam int W  = 1;
    localparam int NC = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [W-1:0]      din;
    logic              din_valid;
    logic              sync;
    logic [NC*W-1:0]   ch_out;
    logic [NC*W-1:0]   frame_out;
    logic              frame_valid;
    logic [2:0]        ch_idx;
    logic              locked;
    logic              sync_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_ch [NC];
    logic [W-1:0] m_frame [NC];
    int           m_idx;
    bit           m_locked;
    bit           m_fv;
    bit           m_se;
    int           fv_count;

    tdm_demux_8ch #(.WIDTH(W), .NUM_CH(NC)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .ch_out     (ch_out),
        .frame_out  (frame_out),
        .frame_valid(frame_valid),
        .ch_idx     (ch_idx),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NC*W-1:0] pack(input logic [W-1:0] a [NC]);
        logic [NC*W-1:0] v;
        v = '0;
        for (int k = 0; k < NC; k++) v[k*W +: W] = a[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_ch[k]    = '0;
            m_frame[k] = '0;
        end
        m_idx = 0; m_locked = 0; m_fv = 0; m_se = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ch_out"},      64'(ch_out),      64'(pack(m_ch)));
        check({tag, ".frame_out"},   64'(frame_out),   64'(pack(m_frame)));
        check({tag, ".frame_valid"}, 64'(frame_valid), 64'(m_fv));
        check({tag, ".ch_idx"},      64'(ch_idx),      64'(m_idx));
        check({tag, ".locked"},      64'(locked),      64'(m_locked));
        check({tag, ".sync_err"},    64'(sync_err),    64'(m_se));
    endtask

    // One clock of stimulus, then model update and full comparison after the edge.
    task automatic step(input bit v, input bit s, input logic [W-1:0] d, input string tag);
        @(negedge clk);
        din_valid = v; sync = s; din = d;
        @(posedge clk);
        #1;
        m_fv = 0; m_se = 0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_ch[0] = d; m_idx = 1; m_locked = 1;
                end
            end else if (s && m_idx != 0) begin
                m_se = 1; m_ch[0] = d; m_idx = 1;
            end else begin
                m_ch[m_idx] = d;
                if (m_idx == NC - 1) begin
                    m_frame = m_ch;
                    m_fv    = 1;
                end
                m_idx = (m_idx + 1) % NC;
            end
        end
        if (frame_valid) fv_count++;
        compare_all(tag);
    endtask

    initial begin
        logic [7:0] pat;
        logic [NC*W-1:0] prev_frame;
        int fv_before;

        rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0;
        model_reset();
        fv_count = 0;
        #2;
        compare_all("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // HUNT discards unsynced samples
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, "hunt");
        check("hunt.locked", 64'(locked), 64'(0));
        check("hunt.ch_out", 64'(ch_out), 64'(0));

        // Lock and one frame: ch0..ch7 = 0,1,0,1,1,0,0,1
        pat = 8'b1001_1010;
        step(1'b1, 1'b1, pat[0], "lock0");
        check("lock.locked_first_edge", 64'(locked), 64'(1));
        fv_before = fv_count;
        for (int k = 1; k < 8; k++) step(1'b1, 1'b0, pat[k], "lock");
        check("lock.frame_valid_at_ch7", 64'(frame_valid), 64'(1));
        check("lock.frame_out", 64'(frame_out), 64'(8'b1001_1010));
        check("lock.ch_idx_after", 64'(ch_idx), 64'(0));
        check("lock.one_pulse", 64'(fv_count - fv_before), 64'(1));
        step(1'b0, 1'b0, 1'b0, "lock.idle");

        // Freewheel frame with a 3-cycle valid gap mid-frame
        pat = 8'($urandom);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, pat[k], "free");
        for (int g = 0; g < 3; g++) step(1'b0, 1'b0, 1'b1, "free.gap");
        check("free.no_pulse_in_gap", 64'(frame_valid), 64'(0));
        for (int k = 4; k < 8; k++) step(1'b1, 1'b0, pat[k], "free");
        check("free.frame_valid", 64'(frame_valid), 64'(1));
        check("free.frame_out", 64'(frame_out), 64'(pat));

        // Misaligned sync at ch_idx 5
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, "mis.pre");
        check("mis.idx5", 64'(ch_idx), 64'(5));
        prev_frame = frame_out;
        step(1'b1, 1'b1, 1'b1, "mis");
        check("mis.sync_err", 64'(sync_err), 64'(1));
        check("mis.ch0", 64'(ch_out[0]), 64'(1));
        check("mis.ch_idx", 64'(ch_idx), 64'(1));
        check("mis.no_fv", 64'(frame_valid), 64'(0));
        check("mis.frame_hold", 64'(frame_out), 64'(pat));
        step(1'b0, 1'b0, 1'b0, "mis.after");
        check("mis.pulse_1cyc", 64'(sync_err), 64'(0));
        check("mis.frame_hold2", 64'(frame_out), 64'(prev_frame));

        // Sync without valid at ch_idx 3
        step(1'b1, 1'b0, 1'b1, "nv.pre");
        step(1'b1, 1'b0, 1'b0, "nv.pre");
        check("nv.idx3", 64'(ch_idx), 64'(3));
        step(1'b0, 1'b1, 1'b1, "nv");
        check("nv.no_err", 64'(sync_err), 64'(0));
        check("nv.idx_hold", 64'(ch_idx), 64'(3));

        // Async reset mid-frame at ch_idx 4
        step(1'b1, 1'b0, 1'b1, "ar.pre");
        check("ar.idx4", 64'(ch_idx), 64'(4));
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("ar.immediate");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b1, "ar.hunt");
        check("ar.hunt_locked", 64'(locked), 64'(0));

        // Randomized traffic, occasional syncs
        step(1'b1, 1'b1, W'($urandom), "rnd.lock");
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3, 0) != 0), ($urandom_range(11, 0) == 0),
                 W'($urandom), "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
